// File: rtl/pooling_ctrl.sv
// Sequencing controller for the pooling datapath. It latches a layer config, gates and
// tags the input word stream, and counts result words until the layer drains.
module pooling_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_PE     = 4,
  parameter int CFG_WIDTH  = 3,
  parameter int CTRL_WIDTH = 6,
  parameter int DIM_WIDTH  = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [DIM_WIDTH-1:0]   cfg_in_w,
  input  logic [DIM_WIDTH-1:0]   cfg_in_h,
  input  logic [1:0]             cfg_pool_k,
  input  logic                   cfg_mode,
  input  logic [2*DIM_WIDTH-1:0] cfg_out_words,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic                   pool_enable,
  output logic [CFG_WIDTH-1:0]   pool_cfg,
  output logic [CTRL_WIDTH-1:0]  pool_ctrl,
  input  logic                   pool_ready,
  input  logic                   src_valid,
  output logic                   src_ready,
  output logic                   pool_wr_req,
  input  logic                   pool_wr_ready,
  input  logic                   pool_rd_req,
  input  logic                   pool_rd_ready
);

  localparam int SHIFT = $clog2(NUM_PE);
  localparam int CNT_W = 2 * DIM_WIDTH;
  localparam logic [DIM_WIDTH:0] PE_ROUND = (DIM_WIDTH + 1)'(NUM_PE - 1);

  if (DATA_WIDTH < 1 || NUM_PE < 1 || (NUM_PE & (NUM_PE - 1)) != 0 ||
      CFG_WIDTH < 3 || CTRL_WIDTH < 6) begin : g_bad_params
    $error("pooling_ctrl: unsupported parameter combination");
  end

  typedef enum logic [2:0] {S_IDLE, S_CFG, S_RUN, S_DRAIN, S_DONE} state_t;
  state_t state, state_nxt;

  logic [DIM_WIDTH-1:0] wpr, col, row, wpr_new;
  logic [1:0]           k_m1, row_k;
  logic                 mode;
  logic [CNT_W-1:0]     total_in, out_words, in_cnt, out_cnt, out_cnt_nxt, total_new;
  logic [DIM_WIDTH:0]   w_round;
  logic                 zero_dim, accept, counting, rd_hs, overcount;
  logic                 last_word, outs_complete;

  assign w_round   = {1'b0, cfg_in_w} + PE_ROUND;
  assign wpr_new   = DIM_WIDTH'(w_round >> SHIFT);
  assign total_new = CNT_W'(wpr_new) * CNT_W'(cfg_in_h);
  assign zero_dim  = (cfg_in_w == '0) || (cfg_in_h == '0);

  assign accept        = (state == S_RUN) && src_valid && pool_wr_ready;
  assign counting      = state inside {S_RUN, S_DRAIN, S_DONE};
  assign rd_hs         = counting && pool_rd_req && pool_rd_ready;
  assign overcount     = rd_hs && (out_cnt == out_words);
  assign out_cnt_nxt   = (rd_hs && !overcount) ? out_cnt + 1'b1 : out_cnt;
  // Compare against the post-handshake count so done follows the final read by one cycle.
  assign outs_complete = (out_cnt_nxt == out_words);
  assign last_word     = (in_cnt == total_in - 1'b1);

  always_comb begin
    // NOTE: default first so no path through the case leaves state_nxt unassigned (no latch).
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = zero_dim ? S_DONE : S_CFG;
      S_CFG:   if (pool_ready) state_nxt = S_RUN;
      S_RUN:   if (accept && last_word) state_nxt = outs_complete ? S_DONE : S_DRAIN;
      S_DRAIN: if (outs_complete) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);
  assign pool_enable = (state == S_RUN) || (state == S_DRAIN);
  assign src_ready   = (state == S_RUN) && pool_wr_ready;
  assign pool_wr_req = (state == S_RUN) && src_valid;
  assign pool_cfg    = CFG_WIDTH'({mode, k_m1});

  always_comb begin
    pool_ctrl = '0;
    if (state == S_RUN) begin
      pool_ctrl[0] = (row == '0) && (col == '0);
      pool_ctrl[1] = (col == wpr - 1'b1);
      pool_ctrl[2] = last_word;
      pool_ctrl[3] = (row_k == k_m1);
      pool_ctrl[4] = (row_k == 2'd0);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: every register, config latches included, is cleared so pool_cfg reads 0 after reset.
    if (reset) begin
      state     <= S_IDLE;
      wpr       <= '0;
      total_in  <= '0;
      out_words <= '0;
      k_m1      <= '0;
      mode      <= 1'b0;
      col       <= '0;
      row       <= '0;
      row_k     <= '0;
      in_cnt    <= '0;
      out_cnt   <= '0;
      err       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state <= state_nxt;
      if (state == S_IDLE && start) begin
        wpr       <= wpr_new;
        total_in  <= total_new;
        out_words <= cfg_out_words;
        k_m1      <= cfg_pool_k;
        mode      <= cfg_mode;
        col       <= '0;
        row       <= '0;
        row_k     <= '0;
        in_cnt    <= '0;
        out_cnt   <= '0;
        err       <= zero_dim;
      end else begin
        if (accept) begin
          in_cnt <= in_cnt + 1'b1;
          if (col == wpr - 1'b1) begin
            col   <= '0;
            row   <= row + 1'b1;
            row_k <= (row_k == k_m1) ? 2'd0 : row_k + 2'd1;
          end else begin
            col <= col + 1'b1;
          end
        end
        out_cnt <= out_cnt_nxt;
        if (overcount) err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/pooling_ctrl.md
# pooling_ctrl

Sequencing controller for the `pooling` datapath. It accepts a per-layer pooling configuration and drives the pooling unit's `cfg`, `ctrl` and `enable`. It gates the input word stream into the unit, tagging every word with row/window position flags, and counts result words out. It sits between the layer scheduler and the pooling PE array, and signals `done` once the expected number of outputs has drained.

## Interface
- `DATA_WIDTH`, 16, bits per pixel
- `NUM_PE`, 4, pixels per word; power of two
- `CFG_WIDTH`, 3, pooling `cfg` width
- `CTRL_WIDTH`, 6, pooling `ctrl` width
- `DIM_WIDTH`, 10, width of height/width fields
- `clk` in 1 — single clock, rising edge
- `reset` in 1 — synchronous, active-high
- `start` in 1 — launch layer; sampled only in IDLE
- `cfg_in_w`, `cfg_in_h` in DIM_WIDTH — input width/height in pixels
- `cfg_pool_k` in 2 — window size minus 1 (0..3 gives K=1..4)
- `cfg_mode` in 1 — 0 = max, 1 = average
- `cfg_out_words` in 2*DIM_WIDTH — expected output word count
- `busy` out 1 — high outside IDLE
- `done` out 1 — one-cycle pulse at layer end
- `err` out 1 — sticky; zero-dimension config; cleared by next accepted `start`
- `pool_enable` out 1 — enable to pooling unit
- `pool_cfg` out CFG_WIDTH — `{mode, K-1}`
- `pool_ctrl` out CTRL_WIDTH — per-word position flags
- `pool_ready` in 1 — pooling unit idle/ready for new config
- `src_valid` in 1, `src_ready` out 1 — upstream input word handshake
- `pool_wr_req` out 1, `pool_wr_ready` in 1 — word push into pooling
- `pool_rd_req` in 1, `pool_rd_ready` in 1 — pooling result transfer (observed)

## Operation
- **Derived values.** Latched at `start`:
  - `wpr = (in_w + NUM_PE-1) >> log2(NUM_PE)`
  - `total_in = wpr * in_h`, computed to 2*DIM_WIDTH bits.
- **IDLE.**
  - On `start`, latch all `cfg_*` and clear the counters and `err`.
  - If `in_w==0` or `in_h==0`: go to DONE and set `err`.
  - Otherwise go to CFG.
- **CFG.** Drive `pool_cfg` and hold `pool_enable=0`; wait for `pool_ready=1`, then go to RUN.
- **RUN.**
  - `pool_enable=1`.
  - Combinational forwarding: `pool_wr_req = src_valid`, `src_ready = pool_wr_ready`.
  - Each accepted word (`src_valid & pool_wr_ready`) advances the column counter `c` (0..wpr-1) and, at wrap, the row counter `r` (0..in_h-1).
  - After word `total_in` is accepted, go to DRAIN.
- **`pool_ctrl` per word** (valid with `pool_wr_req`):
  - [0] first word of frame
  - [1] last word of row (`c==wpr-1`)
  - [2] last word of frame
  - [3] last row of window (`r mod K == K-1`)
  - [4] first row of window (`r mod K == 0`)
  - [5] = 0
- **Row-in-window counter.** Implement `r mod K` as a 2-bit wrapping counter; do not divide.
- **Output counting.** `out_cnt` increments on `pool_rd_req & pool_rd_ready`, in any state from RUN onward.
- **DRAIN.**
  - `pool_enable=1`, `src_ready=0`, `pool_wr_req=0`.
  - When `out_cnt == out_words`, go to DONE.
  - If `out_words==0`, leave DRAIN immediately.
- **DONE.** Pulse `done` for one cycle, deassert `pool_enable`, return to IDLE.
- **Out-of-sequence inputs.**
  - `start` outside IDLE is ignored.
  - Words offered outside RUN are not accepted (`src_ready=0`).
  - Output overcount (more read handshakes than `out_words`) saturates `out_cnt` and sets `err`.

## Timing
- **Reset values:** state=IDLE; `busy`, `done`, `err`, `pool_enable`, `src_ready`, `pool_wr_req` = 0; `pool_cfg` = 0; `pool_ctrl` = 0; all counters 0.
- **`start` to CFG:** `start` in cycle t puts the FSM in CFG at t+1. If `pool_ready` is already high, the FSM is in RUN at t+2.
- **Zero-dimension path:** DONE at t+1, `done` visible at t+1.
- **Input path:** combinational, zero latency. `pool_ctrl` is decoded from registered counters, so it is stable for the whole cycle `pool_wr_req` is high.
- **`done` latency:** `done` asserts the cycle after the final output handshake, or the cycle after the last input handshake if all outputs were already counted.
- **Reset mid-layer:** returns to IDLE at the next edge with all outputs cleared. Partial counts are discarded.
- **Backpressure:** `pool_wr_ready=0` stalls the counters; the word is not counted until accepted.

## Test plan
- **Nominal 24×24, K=2, max, `out_words`=36.** Stream 144 words.
  - `pool_ctrl[1]` on every 6th word; `[3]` on rows 1, 3, …; `[2]` only on word 144.
  - After 36 reads: `done` pulses once, `busy` drops.
- **Backpressure.** Toggle `pool_wr_ready` randomly, 50%, in the 24×24 case.
  - Exactly 144 words accepted, ctrl flags identical to the no-stall run.
- **Pool-not-ready.** Hold `pool_ready=0` for 20 cycles after `start`.
  - FSM stays in CFG, `src_ready=0`, no words accepted; RUN is entered the cycle after `pool_ready` rises.
- **Zero dimension.** `cfg_in_h=0`.
  - `done` pulses at t+1, `err=1`, no `pool_wr_req`.
  - Next valid `start` clears `err`.
- **K=3 on 6×9 (wpr=2).**
  - `[4]` on rows 0, 3, 6; `[3]` on rows 2, 5, 8.
  - 18 input words, completes with `out_words`=6.
- **Reset mid-RUN after 50 words.** `busy=0` and all outputs 0 the next cycle; a fresh `start` restarts counting at word 0.
